// File: rtl/mmu_bus_ctrl.sv
// CPU-side bus controller: region decode with fixed 1-cycle read return,
// SPART TX/RX FIFOs, sticky unmapped-access fault and SPU result registers for VGA.
module mmu_bus_ctrl #(
  parameter int DATA_W   = 32,
  parameter int TX_DEPTH = 8,
  parameter int RX_DEPTH = 8,
  parameter int SPU_REGS = 16,
  parameter int VGA_CH   = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cpu_req,
  input  logic                        cpu_we,
  input  logic [31:0]                 cpu_addr,
  input  logic [DATA_W-1:0]           cpu_wdata,
  output logic [DATA_W-1:0]           cpu_rdata,
  output logic                        cpu_rvalid,
  output logic                        imem_en,
  output logic [31:0]                 imem_addr,
  input  logic [DATA_W-1:0]           imem_rdata,
  output logic                        dmem_en,
  output logic                        dmem_we,
  output logic [31:0]                 dmem_addr,
  output logic [DATA_W-1:0]           dmem_wdata,
  input  logic [DATA_W-1:0]           dmem_rdata,
  output logic [7:0]                  tx_data,
  output logic                        tx_valid,
  input  logic                        tx_ready,
  input  logic [7:0]                  rx_data,
  input  logic                        rx_valid,
  input  logic                        spu_res_we,
  input  logic [$clog2(SPU_REGS)-1:0] spu_res_addr,
  input  logic [31:0]                 spu_res_data,
  output logic [32*VGA_CH-1:0]        vga_data,
  output logic                        fault
);

  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int RX_AW = $clog2(RX_DEPTH);

  localparam logic [4:0] OFF_TX    = 5'h00;
  localparam logic [4:0] OFF_STAT  = 5'h04;
  localparam logic [4:0] OFF_CNT   = 5'h08;
  localparam logic [4:0] OFF_RX    = 5'h0C;
  localparam logic [4:0] OFF_FADDR = 5'h10;
  localparam logic [4:0] OFF_CLR   = 5'h14;

  typedef enum logic [1:0] {
    SEL_IMEM = 2'd0,
    SEL_DMEM = 2'd1,
    SEL_MMIO = 2'd2,
    SEL_NONE = 2'd3
  } sel_e;

  logic [7:0]      r_tx_mem [TX_DEPTH];
  logic [TX_AW-1:0] r_tx_wp, r_tx_rp;
  logic [TX_AW:0]  r_tx_cnt;
  logic            r_tx_ovf;
  logic [7:0]      r_rx_mem [RX_DEPTH];
  logic [RX_AW-1:0] r_rx_wp, r_rx_rp;
  logic [RX_AW:0]  r_rx_cnt;
  logic            r_rx_ovf;
  logic            r_fault;
  logic [31:0]     r_fault_addr;
  logic            r_rvalid;
  sel_e            r_sel;
  logic [31:0]     r_mmio_val;
  logic [31:0]     r_spu [SPU_REGS];

  logic       w_is_imem, w_is_dmem, w_is_mmio, w_unmapped;
  logic       w_rd, w_wr;
  logic [4:0] w_off;
  sel_e       w_sel;
  logic       w_tx_full, w_tx_pop, w_tx_push_req, w_tx_push, w_tx_ovf_set;
  logic       w_rx_full, w_rx_empty, w_rx_pop, w_rx_push, w_rx_ovf_set;
  logic [2:0] w_clr;
  logic [31:0] w_mmio_rd;

  assign w_is_imem  = (cpu_addr[23:20] == 4'h0);
  assign w_is_dmem  = (cpu_addr[23:20] == 4'h8) || (cpu_addr[23:20] == 4'h9);
  assign w_is_mmio  = (cpu_addr[23:20] == 4'hA);
  assign w_unmapped = cpu_req & ~(w_is_imem | w_is_dmem | w_is_mmio);
  assign w_rd       = cpu_req & ~cpu_we;
  assign w_wr       = cpu_req & cpu_we;
  assign w_off      = cpu_addr[4:0];

  assign imem_en    = cpu_req & w_is_imem;
  assign imem_addr  = {17'h0, cpu_addr[14:0]};
  assign dmem_en    = cpu_req & w_is_dmem;
  assign dmem_we    = dmem_en & cpu_we;
  assign dmem_addr  = {11'h0, cpu_addr[20:0]};
  assign dmem_wdata = cpu_wdata;

  always_comb begin
    if (w_is_imem)      w_sel = SEL_IMEM;
    else if (w_is_dmem) w_sel = SEL_DMEM;
    else if (w_is_mmio) w_sel = SEL_MMIO;
    else                w_sel = SEL_NONE;
  end

  // A full FIFO still accepts a push when it is popped in the same cycle
  assign w_tx_full     = (r_tx_cnt == (TX_AW+1)'(TX_DEPTH));
  assign tx_valid      = (r_tx_cnt != '0);
  assign tx_data       = r_tx_mem[r_tx_rp];
  assign w_tx_pop      = tx_valid & tx_ready;
  assign w_tx_push_req = w_wr & w_is_mmio & (w_off == OFF_TX);
  assign w_tx_push     = w_tx_push_req & (~w_tx_full | w_tx_pop);
  assign w_tx_ovf_set  = w_tx_push_req & w_tx_full & ~w_tx_pop;

  assign w_rx_full     = (r_rx_cnt == (RX_AW+1)'(RX_DEPTH));
  assign w_rx_empty    = (r_rx_cnt == '0);
  assign w_rx_pop      = w_rd & w_is_mmio & (w_off == OFF_RX) & ~w_rx_empty;
  assign w_rx_push     = rx_valid & (~w_rx_full | w_rx_pop);
  assign w_rx_ovf_set  = rx_valid & w_rx_full & ~w_rx_pop;

  assign w_clr = (w_wr & w_is_mmio & (w_off == OFF_CLR)) ? cpu_wdata[2:0] : 3'b000;

  always_comb begin
    w_mmio_rd = '0;
    case (w_off)
      OFF_STAT:  w_mmio_rd[3:0] = {r_tx_ovf, r_rx_ovf, w_tx_full, w_rx_empty};
      OFF_CNT:   w_mmio_rd = {16'(r_rx_cnt), 16'(r_tx_cnt)};
      OFF_RX:    if (!w_rx_empty) w_mmio_rd[7:0] = r_rx_mem[r_rx_rp];
      OFF_FADDR: w_mmio_rd = r_fault_addr;
      default:   w_mmio_rd = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_wp  <= '0;
      r_tx_rp  <= '0;
      r_tx_cnt <= '0;
      r_tx_ovf <= 1'b0;
      for (int i = 0; i < TX_DEPTH; i++) r_tx_mem[i] <= '0;
    end else begin
      if (w_tx_push) begin
        r_tx_mem[r_tx_wp] <= cpu_wdata[7:0];
        r_tx_wp           <= r_tx_wp + TX_AW'(1);
      end
      if (w_tx_pop) r_tx_rp <= r_tx_rp + TX_AW'(1);
      if (w_tx_push & ~w_tx_pop)      r_tx_cnt <= r_tx_cnt + (TX_AW+1)'(1);
      else if (~w_tx_push & w_tx_pop) r_tx_cnt <= r_tx_cnt - (TX_AW+1)'(1);
      if (w_tx_ovf_set)  r_tx_ovf <= 1'b1;
      else if (w_clr[1]) r_tx_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_wp  <= '0;
      r_rx_rp  <= '0;
      r_rx_cnt <= '0;
      r_rx_ovf <= 1'b0;
      for (int i = 0; i < RX_DEPTH; i++) r_rx_mem[i] <= '0;
    end else begin
      if (w_rx_push) begin
        r_rx_mem[r_rx_wp] <= rx_data;
        r_rx_wp           <= r_rx_wp + RX_AW'(1);
      end
      if (w_rx_pop) r_rx_rp <= r_rx_rp + RX_AW'(1);
      if (w_rx_push & ~w_rx_pop)      r_rx_cnt <= r_rx_cnt + (RX_AW+1)'(1);
      else if (~w_rx_push & w_rx_pop) r_rx_cnt <= r_rx_cnt - (RX_AW+1)'(1);
      if (w_rx_ovf_set)  r_rx_ovf <= 1'b1;
      else if (w_clr[2]) r_rx_ovf <= 1'b0;
    end
  end

  // Only the first fault address is kept until software clears the flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fault      <= 1'b0;
      r_fault_addr <= '0;
    end else if (w_unmapped) begin
      r_fault <= 1'b1;
      if (!r_fault) r_fault_addr <= cpu_addr;
    end else if (w_clr[0]) begin
      r_fault <= 1'b0;
    end
  end

  assign fault = r_fault;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rvalid   <= 1'b0;
      r_sel      <= SEL_NONE;
      r_mmio_val <= '0;
    end else begin
      r_rvalid <= w_rd;
      if (w_rd) begin
        r_sel      <= w_sel;
        r_mmio_val <= w_mmio_rd;
      end
    end
  end

  assign cpu_rvalid = r_rvalid;

  always_comb begin
    cpu_rdata = '0;
    if (r_rvalid) begin
      case (r_sel)
        SEL_IMEM: cpu_rdata = imem_rdata;
        SEL_DMEM: cpu_rdata = dmem_rdata;
        SEL_MMIO: cpu_rdata = DATA_W'(r_mmio_val);
        default:  cpu_rdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SPU_REGS; i++) r_spu[i] <= '0;
    end else if (spu_res_we) begin
      r_spu[spu_res_addr] <= spu_res_data;
    end
  end

  for (genvar k = 0; k < VGA_CH; k++) begin : g_vga
    assign vga_data[32*k +: 32] = r_spu[k];
  end

endmodule
